// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - coin codes and dispenser state encoding shared with the vending FSM
package vm_pkg;
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EJECT,
    ST_GAP,
    ST_DONE,
    ST_FAULT
  } disp_state_t;
endpackage

// File: rtl/coin_counter.sv
// rtl/coin_counter.sv - saturating up/down inventory counter, one per denomination
module coin_counter #(
  parameter int CNT_W = 8,
  parameter int INIT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count
);
  localparam logic [CNT_W-1:0] MAX = '1;

  // A simultaneous refill and payout of the same coin cancels out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= CNT_W'(INIT);
    end else if (inc && !dec && count != MAX) begin
      count <= count + 1'b1;
    end else if (dec && !inc && count != '0) begin
      count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/coin_dispenser.sv
// rtl/coin_dispenser.sv - pays change one coin at a time to the hopper, tracks inventory
module coin_dispenser #(
  parameter int CNT_W       = 8,
  parameter int INIT_5      = 20,
  parameter int INIT_10     = 10,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       chg_req,
  output logic             req_ready,
  output logic [1:0]       hop_coin,
  output logic             hop_valid,
  input  logic             hop_ack,
  input  logic             refill_5,
  input  logic             refill_10,
  output logic [CNT_W-1:0] cnt_5,
  output logic [CNT_W-1:0] cnt_10,
  output logic             done,
  output logic             short,
  output logic             fault
);
  import vm_pkg::*;

  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);

  disp_state_t       state, next_state;
  logic              armed, extra;
  logic [1:0]        coin;
  logic [WAIT_W-1:0] wait_cnt;
  logic              accept, plan_ok, plan_two;
  logic [1:0]        plan_coin;
  logic              ack_edge, dec_5, dec_10;
  logic              hop_valid_d, done_d, short_d, fault_d;
  logic [1:0]        hop_coin_d;

  assign accept    = (state == ST_IDLE) && armed && (chg_req == COIN_5 || chg_req == COIN_10);
  assign req_ready = (state == ST_IDLE);
  assign ack_edge  = (state == ST_EJECT) && hop_ack;
  assign dec_5     = ack_edge && (coin == COIN_5);
  assign dec_10    = ack_edge && (coin == COIN_10);

  // Plan is decided from the counts seen on the accepting edge only.
  always_comb begin
    plan_ok   = 1'b0;
    plan_two  = 1'b0;
    plan_coin = COIN_NONE;
    if (chg_req == COIN_5) begin
      if (cnt_5 != '0) begin
        plan_ok   = 1'b1;
        plan_coin = COIN_5;
      end
    end else if (chg_req == COIN_10) begin
      if (cnt_10 != '0) begin
        plan_ok   = 1'b1;
        plan_coin = COIN_10;
      end else if (cnt_5 >= CNT_W'(2)) begin
        plan_ok   = 1'b1;
        plan_two  = 1'b1;
        plan_coin = COIN_5;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (accept && plan_ok) next_state = ST_EJECT;
      ST_EJECT: begin
        if (hop_ack) next_state = extra ? ST_GAP : ST_DONE;
        else if (wait_cnt == WAIT_W'(ACK_TIMEOUT - 1)) next_state = ST_FAULT;
      end
      ST_GAP:   next_state = ST_EJECT;
      ST_DONE:  next_state = ST_IDLE;
      ST_FAULT: next_state = ST_FAULT;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    hop_valid_d = (next_state == ST_EJECT);
    hop_coin_d  = COIN_NONE;
    if (next_state == ST_EJECT) hop_coin_d = (state == ST_IDLE) ? plan_coin : coin;
    done_d  = (next_state == ST_DONE);
    short_d = accept && !plan_ok;
    fault_d = (next_state == ST_FAULT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      armed     <= 1'b1;
      extra     <= 1'b0;
      coin      <= COIN_NONE;
      wait_cnt  <= '0;
      hop_valid <= 1'b0;
      hop_coin  <= COIN_NONE;
      done      <= 1'b0;
      short     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= next_state;
      hop_valid <= hop_valid_d;
      hop_coin  <= hop_coin_d;
      done      <= done_d;
      short     <= short_d;
      fault     <= fault_d;
      if (chg_req == 2'b00) armed <= 1'b1;
      else if (accept) armed <= 1'b0;
      if (accept && plan_ok) begin
        coin  <= plan_coin;
        extra <= plan_two;
      end else if (ack_edge) begin
        extra <= 1'b0;
      end
      if (state != ST_EJECT) wait_cnt <= '0;
      else if (!hop_ack) wait_cnt <= wait_cnt + 1'b1;
    end
  end

  coin_counter #(.CNT_W(CNT_W), .INIT(INIT_5)) u_cnt_5 (
    .clk(clk), .rst(rst), .inc(refill_5), .dec(dec_5), .count(cnt_5)
  );

  coin_counter #(.CNT_W(CNT_W), .INIT(INIT_10)) u_cnt_10 (
    .clk(clk), .rst(rst), .inc(refill_10), .dec(dec_10), .count(cnt_10)
  );
endmodule

// File: tb/tb_coin_dispenser.sv
// tb/tb_coin_dispenser.sv - scoreboard bench for coin_dispenser
module tb_coin_dispenser;
  import vm_pkg::*;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       chg_req = 2'b00;
  logic             req_ready;
  logic [1:0]       hop_coin;
  logic             hop_valid;
  logic             hop_ack = 1'b0;
  logic             refill_5 = 1'b0;
  logic             refill_10 = 1'b0;
  logic [CNT_W-1:0] cnt_5, cnt_10;
  logic             done, short, fault;

  int vectors = 0;
  int errors  = 0;
  int m5, m10;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  coin_dispenser #(.CNT_W(CNT_W), .INIT_5(20), .INIT_10(10), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .chg_req(chg_req), .req_ready(req_ready),
    .hop_coin(hop_coin), .hop_valid(hop_valid), .hop_ack(hop_ack),
    .refill_5(refill_5), .refill_10(refill_10), .cnt_5(cnt_5), .cnt_10(cnt_10),
    .done(done), .short(short), .fault(fault)
  );

  task automatic test_reset;
    rst = 1'b0;
    chg_req = 2'b00;
    hop_ack = 1'b0;
    refill_5 = 1'b0;
    refill_10 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    m5 = 20;
    m10 = 10;
    exp_q.delete();
    vectors++;
    if (cnt_5 !== 8'd20 || cnt_10 !== 8'd10 || req_ready !== 1'b1 || hop_valid !== 1'b0 ||
        hop_coin !== 2'b00 || fault !== 1'b0 || done !== 1'b0 || short !== 1'b0) begin
      errors++;
      $display("FAIL reset: cnt5=%0d cnt10=%0d rdy=%b hv=%b hc=%b flt=%b done=%b short=%b, want 20 10 1 0 00 0 0 0",
               cnt_5, cnt_10, req_ready, hop_valid, hop_coin, fault, done, short);
    end
  endtask

  // Drives one request and acts as the hopper; expected coins go through exp_q.
  task automatic run_payout(input logic [1:0] req, input int ncoin, input logic [1:0] coin,
                            input int ack_dly, input bit hold, input bit refill_on_ack);
    logic [1:0] exp_coin;
    for (int i = 0; i < ncoin; i++) exp_q.push_back(coin);
    chg_req = req;
    @(negedge clk);
    if (!hold) chg_req = 2'b00;
    for (int c = 0; c < ncoin; c++) begin
      exp_coin = exp_q.pop_front();
      vectors++;
      if (hop_valid !== 1'b1 || hop_coin !== exp_coin || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL eject_start coin%0d: hv=%b hc=%b rdy=%b, want 1 %b 0", c, hop_valid, hop_coin, req_ready, exp_coin);
      end
      for (int d = 0; d < ack_dly; d++) begin
        @(negedge clk);
        vectors++;
        if (hop_valid !== 1'b1 || hop_coin !== exp_coin) begin
          errors++;
          $display("FAIL eject_hold coin%0d: hv=%b hc=%b, want 1 %b", c, hop_valid, hop_coin, exp_coin);
        end
      end
      hop_ack = 1'b1;
      if (refill_on_ack) begin
        refill_5  = (exp_coin == COIN_5);
        refill_10 = (exp_coin == COIN_10);
      end
      @(negedge clk);
      hop_ack = 1'b0;
      refill_5 = 1'b0;
      refill_10 = 1'b0;
      if (!refill_on_ack) begin
        if (exp_coin == COIN_5) m5--;
        else m10--;
      end
      vectors++;
      if (cnt_5 !== CNT_W'(m5) || cnt_10 !== CNT_W'(m10)) begin
        errors++;
        $display("FAIL count_after_ack coin%0d: cnt5=%0d cnt10=%0d, want %0d %0d", c, cnt_5, cnt_10, m5, m10);
      end
      if (c < ncoin - 1) begin
        vectors++;
        if (hop_valid !== 1'b0 || hop_coin !== 2'b00 || done !== 1'b0) begin
          errors++;
          $display("FAIL gap: hv=%b hc=%b done=%b, want 0 00 0", hop_valid, hop_coin, done);
        end
        @(negedge clk);
      end
    end
    vectors++;
    if (done !== 1'b1 || hop_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b hv=%b rdy=%b, want 1 0 0", done, hop_valid, req_ready);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || req_ready !== 1'b1 || hop_valid !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle: done=%b rdy=%b hv=%b, want 0 1 0", done, req_ready, hop_valid);
    end
  endtask

  task automatic check_short(input logic [1:0] req);
    chg_req = req;
    @(negedge clk);
    chg_req = 2'b00;
    vectors++;
    if (short !== 1'b1 || hop_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL short_pulse req=%b: short=%b hv=%b rdy=%b, want 1 0 1", req, short, hop_valid, req_ready);
    end
    @(negedge clk);
    vectors++;
    if (short !== 1'b0 || hop_valid !== 1'b0 || cnt_5 !== CNT_W'(m5) || cnt_10 !== CNT_W'(m10)) begin
      errors++;
      $display("FAIL short_after req=%b: short=%b hv=%b cnt5=%0d cnt10=%0d, want 0 0 %0d %0d",
               req, short, hop_valid, cnt_5, cnt_10, m5, m10);
    end
  endtask

  task automatic test_single_5;
    run_payout(COIN_5, 1, COIN_5, 3, 1'b0, 1'b0);
  endtask

  task automatic test_substitute;
    for (int i = 0; i < 10; i++) run_payout(COIN_10, 1, COIN_10, i % 2, 1'b0, 1'b0);
    run_payout(COIN_10, 2, COIN_5, 1, 1'b0, 1'b0);
  endtask

  task automatic test_short;
    for (int i = 0; i < 8; i++) run_payout(COIN_10, 2, COIN_5, 0, 1'b0, 1'b0);
    check_short(COIN_10);
    run_payout(COIN_5, 1, COIN_5, 0, 1'b0, 1'b0);
    check_short(COIN_5);
    refill_5 = 1'b1;
    repeat (2) @(negedge clk);
    refill_5 = 1'b0;
    m5 += 2;
    vectors++;
    if (cnt_5 !== CNT_W'(m5)) begin
      errors++;
      $display("FAIL refill_idle: cnt5=%0d, want %0d", cnt_5, m5);
    end
    chg_req = 2'b11;
    repeat (2) @(negedge clk);
    chg_req = 2'b00;
    vectors++;
    if (hop_valid !== 1'b0 || short !== 1'b0 || req_ready !== 1'b1 || cnt_5 !== CNT_W'(m5)) begin
      errors++;
      $display("FAIL reserved_ignored: hv=%b short=%b rdy=%b cnt5=%0d, want 0 0 1 %0d", hop_valid, short, req_ready, cnt_5, m5);
    end
  endtask

  task automatic test_fault;
    test_reset();
    chg_req = COIN_5;
    @(negedge clk);
    chg_req = 2'b00;
    repeat (15) @(negedge clk);
    vectors++;
    if (hop_valid !== 1'b1 || fault !== 1'b0) begin
      errors++;
      $display("FAIL pre_timeout: hv=%b fault=%b, want 1 0", hop_valid, fault);
    end
    @(negedge clk);
    vectors++;
    if (fault !== 1'b1 || hop_valid !== 1'b0 || req_ready !== 1'b0 || cnt_5 !== 8'd20) begin
      errors++;
      $display("FAIL timeout: fault=%b hv=%b rdy=%b cnt5=%0d, want 1 0 0 20", fault, hop_valid, req_ready, cnt_5);
    end
    chg_req = COIN_10;
    refill_5 = 1'b1;
    @(negedge clk);
    refill_5 = 1'b0;
    @(negedge clk);
    chg_req = 2'b00;
    vectors++;
    if (fault !== 1'b1 || hop_valid !== 1'b0 || cnt_5 !== 8'd21 || cnt_10 !== 8'd10) begin
      errors++;
      $display("FAIL fault_sticky: fault=%b hv=%b cnt5=%0d cnt10=%0d, want 1 0 21 10", fault, hop_valid, cnt_5, cnt_10);
    end
    test_reset();
  endtask

  task automatic test_back_to_back;
    run_payout(COIN_10, 1, COIN_10, 2, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    vectors++;
    if (hop_valid !== 1'b0 || req_ready !== 1'b1 || cnt_10 !== 8'd10) begin
      errors++;
      $display("FAIL held_level_once: hv=%b rdy=%b cnt10=%0d, want 0 1 10", hop_valid, req_ready, cnt_10);
    end
    chg_req = 2'b00;
    @(negedge clk);
    run_payout(COIN_10, 1, COIN_10, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_5();
    test_substitute();
    test_short();
    test_fault();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/coin_dispenser.md
Name: coin_dispenser

Overview:
- Change pay-out unit that sits downstream of the vending FSM's 2-bit change output and drives the coin hopper.
- Accepts a change request of 5 rs or 10 rs.
- Pays it out one coin at a time over a valid/ack handshake with the hopper.
- Tracks per-denomination coin inventory, substitutes two 5 rs coins when no 10 rs coin is stocked, and flags requests it cannot pay or a hopper that stops responding.

Parameters:
CNT_W, 8, width of each inventory counter
INIT_5, 20, 5 rs coin count loaded at reset
INIT_10, 10, 10 rs coin count loaded at reset
ACK_TIMEOUT, 16, cycles in EJECT without hop_ack before FAULT

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
chg_req  in  2  00 none, 01 return 5 rs, 10 return 10 rs, 11 reserved (ignored)
req_ready  out  1  high only in IDLE
hop_coin  out  2  coin to eject: 00 none, 01 5 rs, 10 10 rs
hop_valid  out  1  eject request to hopper
hop_ack  in  1  hopper has ejected the presented coin
refill_5  in  1  add one 5 rs coin this cycle
refill_10  in  1  add one 10 rs coin this cycle
cnt_5  out  CNT_W  current 5 rs inventory
cnt_10  out  CNT_W  current 10 rs inventory
done  out  1  one-cycle pulse after the final coin of a request
short  out  1  one-cycle pulse: request could not be paid
fault  out  1  sticky hopper timeout, cleared only by reset

Behaviour:
- Reset (rst=0, async): state IDLE, cnt_5=INIT_5, cnt_10=INIT_10, armed=1, hop_valid=0, hop_coin=00, done=0, short=0, fault=0, req_ready=1.
- States: IDLE, EJECT, GAP, DONE, FAULT.
- Request acceptance:
  - A request is accepted on the clk edge where state=IDLE, armed=1 and chg_req is 01 or 10.
  - Acceptance clears armed. armed is set again on any edge where chg_req=00.
  - A held level therefore pays out only once. chg_req=11 and requests outside IDLE are ignored.
- Pay plan, fixed at acceptance:
  - 01 with cnt_5>=1: one 5 rs coin.
  - 10 with cnt_10>=1: one 10 rs coin.
  - 10 with cnt_10=0 and cnt_5>=2: two 5 rs coins.
  - Any other case: short=1 for the next cycle, state stays IDLE, inventory unchanged. There is no partial payout.
- EJECT:
  - Entered the cycle after acceptance (latency 1): hop_valid=1, hop_coin holds the current coin code.
  - On the edge with hop_ack=1:
    - The matching counter decrements.
    - If a coin remains, go to GAP; otherwise go to DONE.
- GAP: one cycle with hop_valid=0 and hop_coin=00, then EJECT for the next coin.
- DONE: done=1 for one cycle, then IDLE.
- Timeout:
  - A wait counter resets on entry to EJECT and increments each EJECT cycle without hop_ack.
  - When it reaches ACK_TIMEOUT, go to FAULT.
- FAULT: fault=1, hop_valid=0, req_ready=0. Held until rst=0. The unpaid coin is not decremented.
- Refill:
  - refill_x increments its counter, saturating at 2^CNT_W-1. Refill is accepted in every state, including FAULT.
  - Refill on the same edge as a decrement of the same denomination leaves the counter unchanged.
- hop_ack outside EJECT is ignored.
- The pay plan uses counts sampled at acceptance. Refills during payout never alter the plan.
- Outputs hop_valid, hop_coin, done, short and fault are registered.

Decomposition:
- Shared package vm_pkg:
  - Coin code constants COIN_NONE=00, COIN_5=01, COIN_10=10, shared with the vending FSM.
  - Dispenser state encoding.
- Sub-module coin_counter: CNT_W saturating up/down counter with inc, dec and reset-load value. Instantiated once per denomination.

Test Plan:
1. Reset with defaults -> cnt_5=20, cnt_10=10, req_ready=1, hop_valid=0, fault=0.
2. chg_req=01 for 1 cycle, hop_ack raised 3 cycles after hop_valid -> hop_coin=01 from the cycle after acceptance; cnt_5 goes to 19 on the ack edge; done pulses the following cycle.
3. INIT_10=0, chg_req=10 -> two EJECT phases with hop_coin=01, one GAP cycle between them; cnt_5 goes 20->19->18; single done pulse.
4. INIT_5=1, INIT_10=0, chg_req=10 -> short=1 for one cycle; hop_valid stays 0; counts unchanged.
5. chg_req=01, hop_ack held low -> fault=1 after 16 EJECT cycles; hop_valid=0; req_ready=0; a further chg_req is ignored; rst=0 restores IDLE and initial counts.
6. chg_req=10 held high through done, with refill_10 asserted on the ack edge -> exactly one coin ejected; cnt_10 stays 10; a second payout occurs only after chg_req returns to 00 and then reasserts.
